// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs one-entry MD buffer.
// Optional RF_ZERO_FILTER_EN suppresses RF writes to address 0.
module rf_write_arbiter #(
  parameter int AWL        = 5,
  parameter int DWL        = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           WBWE,
  input  logic [AWL-1:0] WBWA,
  input  logic [DWL-1:0] WBWD,
  input  logic           MDVALID,
  input  logic [AWL-1:0] MDWA,
  input  logic [DWL-1:0] MDWD,
  output logic           MDREADY,
  output logic           RFWE,
  output logic [AWL-1:0] RFWA,
  output logic [DWL-1:0] RFWD,
  output logic           BUFV,
  output logic [AWL-1:0] BUFWA,
  output logic           STALLREQ
);

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    FORCE
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t         state;
  logic [AWL-1:0] buf_wa;
  logic [DWL-1:0] buf_wd;
  logic [3:0]     cnt;
  logic [3:0]     cnt_nxt;
  logic           wb_go;
  logic           buf_keep;
  logic           drain;

`ifdef RF_ZERO_FILTER_EN
  // Address-0 writes complete but never reach the RF port.
  assign wb_go    = WBWE && (WBWA != '0);
  assign buf_keep = (buf_wa != '0);
`else
  assign wb_go    = WBWE;
  assign buf_keep = 1'b1;
`endif

  assign drain    = (state != EMPTY) && !wb_go;
  assign cnt_nxt  = cnt + 4'd1;
  assign MDREADY  = (state == EMPTY);
  assign BUFV     = (state != EMPTY);
  assign BUFWA    = BUFV ? buf_wa : '0;
  assign STALLREQ = (state == FORCE);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= EMPTY;
      RFWE   <= 1'b0;
      RFWA   <= '0;
      RFWD   <= '0;
      buf_wa <= '0;
      buf_wd <= '0;
      cnt    <= '0;
    end else begin
      if (wb_go) begin
        RFWE <= 1'b1;
        RFWA <= WBWA;
        RFWD <= WBWD;
      end else if (drain && buf_keep) begin
        RFWE <= 1'b1;
        RFWA <= buf_wa;
        RFWD <= buf_wd;
      end else begin
        RFWE <= 1'b0;
      end

      unique case (state)
        EMPTY: begin
          if (MDVALID) begin
            buf_wa <= MDWA;
            buf_wd <= MDWD;
            cnt    <= '0;
            state  <= HELD;
          end
        end
        HELD: begin
          if (drain) begin
            state <= EMPTY;
          end else if (cnt_nxt >= LIM) begin
            cnt   <= LIM;
            state <= FORCE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        FORCE: begin
          if (drain) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic
// against a transaction-level model of the buffer and write port.
module tb_rf_write_arbiter;

  localparam int AWL = 5;
  localparam int DWL = 32;
  localparam int LIM = 4;
`ifdef RF_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RSTN;
  logic           WBWE;
  logic [AWL-1:0] WBWA;
  logic [DWL-1:0] WBWD;
  logic           MDVALID;
  logic [AWL-1:0] MDWA;
  logic [DWL-1:0] MDWD;
  logic           MDREADY;
  logic           RFWE;
  logic [AWL-1:0] RFWA;
  logic [DWL-1:0] RFWD;
  logic           BUFV;
  logic [AWL-1:0] BUFWA;
  logic           STALLREQ;

  int tests = 0;
  int fails = 0;

  bit             m_held = 1'b0;
  logic [AWL-1:0] m_wa   = '0;
  logic [DWL-1:0] m_wd   = '0;
  int             m_wait = 0;
  logic           m_rfwe = 1'b0;
  logic [AWL-1:0] m_rfwa = '0;
  logic [DWL-1:0] m_rfwd = '0;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(
    .AWL(AWL),
    .DWL(DWL),
    .STARVE_LIM(LIM)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .WBWE(WBWE),
    .WBWA(WBWA),
    .WBWD(WBWD),
    .MDVALID(MDVALID),
    .MDWA(MDWA),
    .MDWD(MDWD),
    .MDREADY(MDREADY),
    .RFWE(RFWE),
    .RFWA(RFWA),
    .RFWD(RFWD),
    .BUFV(BUFV),
    .BUFWA(BUFWA),
    .STALLREQ(STALLREQ)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic cyc(input logic           rstn,
                     input logic           wbwe,
                     input logic [AWL-1:0] wa,
                     input logic [DWL-1:0] wd,
                     input logic           mdv,
                     input logic [AWL-1:0] mwa,
                     input logic [DWL-1:0] mwd);
    bit wb_real;
    bit stall;
    RSTN = rstn;
    WBWE = wbwe;
    WBWA = wa;
    WBWD = wd;
    MDVALID = mdv;
    MDWA = mwa;
    MDWD = mwd;
    if (!rstn) begin
      m_held = 1'b0;
      m_wa = '0;
      m_wd = '0;
      m_wait = 0;
      m_rfwe = 1'b0;
      m_rfwa = '0;
      m_rfwd = '0;
    end else begin
      wb_real = wbwe && !(ZF && wa == '0);
      m_rfwe = 1'b0;
      if (wb_real) begin
        m_rfwe = 1'b1;
        m_rfwa = wa;
        m_rfwd = wd;
      end
      if (m_held) begin
        if (!wb_real) begin
          m_held = 1'b0;
          if (!(ZF && m_wa == '0)) begin
            m_rfwe = 1'b1;
            m_rfwa = m_wa;
            m_rfwd = m_wd;
          end
        end else begin
          m_wait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
        end
      end else if (mdv) begin
        m_held = 1'b1;
        m_wa = mwa;
        m_wd = mwd;
        m_wait = 0;
      end
    end
    stall = m_held && (m_wait >= LIM);
    @(posedge CLK);
    #1;
    chk("rfwe", 64'(RFWE), 64'(m_rfwe));
    chk("rfwa", 64'(RFWA), 64'(m_rfwa));
    chk("rfwd", 64'(RFWD), 64'(m_rfwd));
    chk("bufv", 64'(BUFV), 64'(m_held));
    chk("bufwa", 64'(BUFWA), m_held ? 64'(m_wa) : 64'(0));
    chk("mdready", 64'(MDREADY), 64'(!m_held));
    chk("stallreq", 64'(STALLREQ), 64'(stall));
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    RSTN = 1'b0;
    WBWE = 1'b0;
    WBWA = '0;
    WBWD = '0;
    MDVALID = 1'b0;
    MDWA = '0;
    MDWD = '0;
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("rst_mdready", 64'(MDREADY), 64'(1));
    chk("rst_bufv", 64'(BUFV), 64'(0));
    chk("rst_rfwe", 64'(RFWE), 64'(0));

    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("wb_we", 64'(RFWE), 64'(1));
    chk("wb_wa", 64'(RFWA), 64'(5));
    chk("wb_wd", 64'(RFWD), 64'hDEADBEEF);
    idle();
    chk("wb_we_off", 64'(RFWE), 64'(0));

    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'h12345678);
    chk("md_ready_lo", 64'(MDREADY), 64'(0));
    chk("md_bufwa", 64'(BUFWA), 64'(9));
    idle();
    chk("md_we", 64'(RFWE), 64'(1));
    chk("md_wa", 64'(RFWA), 64'(9));
    chk("md_wd", 64'(RFWD), 64'h12345678);
    chk("md_ready_hi", 64'(MDREADY), 64'(1));

    cyc(1'b1, 1'b1, 5'd2, 32'h1, 1'b1, 5'd11, 32'hCAFE0011);
    for (int i = 1; i <= LIM; i++) begin
      cyc(1'b1, 1'b1, 5'd2, 32'(i), 1'b0, '0, '0);
      chk("starve_stall", 64'(STALLREQ), 64'(i == LIM));
    end
    cyc(1'b1, 1'b1, 5'd2, 32'h99, 1'b0, '0, '0);
    chk("force_hold", 64'(STALLREQ), 64'(1));
    idle();
    chk("force_drain_wa", 64'(RFWA), 64'(11));
    chk("force_stall_off", 64'(STALLREQ), 64'(0));
    chk("force_bufv_off", 64'(BUFV), 64'(0));

    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'h3333_0000);
    cyc(1'b1, 1'b1, 5'd3, 32'hAAAA, 1'b0, '0, '0);
    chk("order_wb", 64'(RFWD), 64'hAAAA);
    idle();
    chk("order_md", 64'(RFWD), 64'h3333_0000);

    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 32'h7777);
    chk("rst_held", 64'(BUFWA), 64'(7));
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, 32'h8888);
    chk("rst_mid_bufv", 64'(BUFV), 64'(0));
    chk("rst_mid_ready", 64'(MDREADY), 64'(1));
    idle();
    chk("rst_no_write", 64'(RFWE), 64'(0));

    cyc(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
`ifdef RF_ZERO_FILTER_EN
    chk("zero_we", 64'(RFWE), 64'(0));
`else
    chk("zero_we", 64'(RFWE), 64'(1));
    chk("zero_wa", 64'(RFWA), 64'(0));
`endif

    for (int n = 0; n < 2000; n++) begin
      logic           r;
      logic           we;
      logic [AWL-1:0] a;
      logic           mv;
      logic [AWL-1:0] ma;
      r  = ($urandom_range(0, 99) != 0);
      we = ($urandom_range(0, 9) < 6);
      a  = ($urandom_range(0, 3) == 0) ? '0 : AWL'($urandom);
      mv = ($urandom_range(0, 1) == 1);
      ma = ($urandom_range(0, 3) == 0) ? '0 : AWL'($urandom);
      cyc(r, we, a, $urandom, mv, ma, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
